// File: rtl/fiapp_run_ctrl_if.sv
// Host/DUT signal bundle for the fault-injection run controller.
// master = host plus DUT-output side, slave = the run controller.
interface fiapp_run_ctrl_if #(
    parameter int CNT_W = 65,
    parameter int LEN_W = 16,
    parameter int ERR_W = 8
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] run_len;
    logic [7:0]       pattern;
    logic             dut_reset;
    logic             dut_enable;
    logic             dut_a;
    logic             dut_o1;
    logic             dut_o2;
    logic [CNT_W-1:0] dut_o4;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [LEN_W-1:0] first_err_cyc;

    modport master (
        output start, abort, run_len, pattern, dut_o1, dut_o2, dut_o4,
        input  dut_reset, dut_enable, dut_a, busy, done, pass, err_cnt, first_err_cyc
    );

    modport slave (
        input  start, abort, run_len, pattern, dut_o1, dut_o2, dut_o4,
        output dut_reset, dut_enable, dut_a, busy, done, pass, err_cnt, first_err_cyc
    );
endinterface

// File: rtl/fiapp_run_ctrl.sv
// Test-run sequencer: drives the fiapp datapath, checks it against shadow models.
// done arrives run_len+5 cycles after an accepted start; start while busy is dropped.
module fiapp_run_ctrl #(
    parameter int CNT_W = 65,
    parameter int LEN_W = 16,
    parameter int ERR_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    fiapp_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, CHECK, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] run_last;
    logic [LEN_W-1:0] rcnt;
    logic [LEN_W-1:0] cyc;
    logic [7:0]       pat_q;
    logic             drain_q;
    logic             rst_q;
    logic             en_q;
    logic             a_q;
    logic             sq1;
    logic             sq2;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] scnt_inc;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_nxt;
    logic [LEN_W-1:0] ferr_q;
    logic             pass_q;
    logic             chk_act;
    logic             cnt_bad;
    logic             mism;
    logic [2:0]       a_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ARM;
            ARM:     state_nxt = (len_q == '0) ? DRAIN : RUN;
            RUN:     if (rcnt == run_last) state_nxt = DRAIN;
            DRAIN:   if (drain_q) state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) state_nxt = IDLE;
    end

    assign run_last = len_q - LEN_W'(1);
    assign chk_act  = (state == ARM) || (state == RUN) || (state == DRAIN) || (state == CHECK);
    assign cnt_bad  = (state == CHECK) && (bus.dut_o4 != scnt);
    assign mism     = chk_act && ((bus.dut_o1 != sq1) || (bus.dut_o2 != sq2) || cnt_bad);
    assign err_nxt  = (mism && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    // Outputs are registered from the next state, so index the pattern for the coming RUN cycle.
    assign a_idx    = (state == RUN) ? rcnt[2:0] + 3'd1 : 3'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q   <= '0;
            pat_q   <= '0;
            rcnt    <= '0;
            cyc     <= '0;
            drain_q <= 1'b0;
            rst_q   <= 1'b1;
            en_q    <= 1'b0;
            a_q     <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '1;
            pass_q  <= 1'b0;
        end else begin
            rst_q   <= (state_nxt == IDLE);
            en_q    <= (state_nxt == RUN);
            a_q     <= (state_nxt == RUN) && pat_q[a_idx];
            drain_q <= (state == DRAIN) && !drain_q;
            if (state == RUN) rcnt <= rcnt + LEN_W'(1);
            if (state == IDLE && bus.start) begin
                len_q  <= bus.run_len;
                pat_q  <= bus.pattern;
                rcnt   <= '0;
                cyc    <= '0;
                err_q  <= '0;
                ferr_q <= '1;
            end else if (chk_act) begin
                if (cyc != '1) cyc <= cyc + LEN_W'(1);
                err_q <= err_nxt;
                if (mism && err_q == '0) ferr_q <= cyc;
            end
            if (state == CHECK && state_nxt == DONE) pass_q <= (err_nxt == '0);
        end
    end

    // Shadows follow the registered DUT controls, so they see exactly what the DUT sees.
    always_comb begin
        scnt_inc     = scnt + CNT_W'(1);
        scnt_inc[32] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sq1  <= 1'b0;
            sq2  <= 1'b0;
            scnt <= '0;
        end else if (rst_q) begin
            sq1  <= 1'b0;
            sq2  <= 1'b0;
            scnt <= '0;
        end else begin
            sq1  <= en_q ? a_q : sq1;
            sq2  <= sq1;
            scnt <= scnt_inc;
        end
    end

    assign bus.dut_reset     = rst_q;
    assign bus.dut_enable    = en_q;
    assign bus.dut_a         = a_q;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.pass          = pass_q;
    assign bus.err_cnt       = err_q;
    assign bus.first_err_cyc = ferr_q;

endmodule
